// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer and instruction memory.
interface fetch_sequencer_if;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_data;
    logic        imem_ready;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_data,
        input  imem_ready
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_data,
        output imem_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// LC3 instruction-cycle sequencer: owns STAGE, PC and IR, fetches over a
// req/ready bus, detects HALT (TRAP x25) and fetch timeouts, counts retires.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC      = 16'h3000,
    parameter int          FETCH_TIMEOUT = 16,
    parameter int          CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic [1:0]          stage,
    output logic [15:0]         pc,
    output logic [15:0]         ir,
    fetch_sequencer_if.master   imem,
    input  logic                pc_le,
    input  logic                pc_control,
    input  logic [15:0]         alu_y,
    input  logic                next_stage_le,
    input  logic [1:0]          next_stage,
    output logic                halted,
    output logic                fetch_err,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int                WAIT_W     = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam bit                TIMEOUT_EN = (FETCH_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(FETCH_TIMEOUT - 1);
    localparam logic [15:0]       HALT_INSTR = 16'hF025;

    // Low two bits are the STAGE encoding; HALT shares 11 with FETCH.
    typedef enum logic [2:0] {
        ST_DECODE    = 3'b000,
        ST_EXECUTE   = 3'b001,
        ST_WRITEBACK = 3'b010,
        ST_FETCH     = 3'b011,
        ST_HALT      = 3'b111
    } state_t;

    state_t            state_reg;
    logic [15:0]       pc_reg;
    logic [15:0]       ir_reg;
    logic              halted_reg;
    logic              fetch_err_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [WAIT_W-1:0] wait_reg;

    state_t            seq_next;
    logic              seq_exit;
    logic              req_now;
    logic [15:0]       pc_next;

    always_comb begin
        seq_next = ST_FETCH;
        case (state_reg)
            ST_DECODE:  seq_next = ST_EXECUTE;
            ST_EXECUTE: seq_next = ST_WRITEBACK;
            default:    seq_next = ST_FETCH;
        endcase
        if (next_stage_le) begin
            seq_next = state_t'({1'b0, next_stage});
        end
        seq_exit = (seq_next == ST_FETCH);
        pc_next  = pc_control ? alu_y : pc_reg + 16'd1;
        req_now  = run && (state_reg == ST_FETCH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_FETCH;
            pc_reg        <= RESET_PC;
            ir_reg        <= 16'h0000;
            halted_reg    <= 1'b0;
            fetch_err_reg <= 1'b0;
            count_reg     <= '0;
            wait_reg      <= '0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (req_now) begin
                        // A ready arriving on the last allowed wait cycle still wins.
                        if (imem.imem_ready) begin
                            ir_reg    <= imem.imem_data;
                            state_reg <= ST_DECODE;
                            wait_reg  <= '0;
                        end else if (TIMEOUT_EN && wait_reg == WAIT_LAST) begin
                            state_reg     <= ST_HALT;
                            halted_reg    <= 1'b1;
                            fetch_err_reg <= 1'b1;
                        end else begin
                            wait_reg <= wait_reg + 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                end
                default: begin
                    if (state_reg == ST_EXECUTE && pc_le) begin
                        pc_reg <= pc_next;
                    end
                    if (seq_exit) begin
                        count_reg <= count_reg + CNT_W'(1);
                        if (ir_reg == HALT_INSTR) begin
                            state_reg  <= ST_HALT;
                            halted_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_FETCH;
                        end
                    end else begin
                        state_reg <= seq_next;
                    end
                end
            endcase
        end
    end

    assign stage          = state_reg[1:0];
    assign pc             = pc_reg;
    assign ir             = ir_reg;
    assign halted         = halted_reg;
    assign fetch_err      = fetch_err_reg;
    assign instr_count    = count_reg;
    assign imem.imem_addr = pc_reg;
    assign imem.imem_req  = req_now;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the LC3 instruction cycle: the 2-bit STAGE register, the PC and the IR.
- Fetches instructions from instruction memory over a req/ready handshake.
- Drives STAGE to the control unit and consumes the control unit's PC_LE, PC_CONTROL, NEXT_STAGE_LE and NEXT_STAGE outputs.
- Detects HALT (TRAP x25), detects fetch timeouts, and counts retired instructions.

Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset.
- FETCH_TIMEOUT, 16, maximum wait cycles for IMEM_READY; 0 disables the timeout.
- CNT_W, 16, width of INSTR_COUNT.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- RUN  in  1  enables issuing new fetches.
- STAGE  out  2  00=DECODE, 01=EXECUTE, 10=WRITEBACK, 11=FETCH.
- PC  out  16  current program counter.
- IR  out  16  current instruction.
- IMEM_ADDR  out  16  fetch address; always equal to PC.
- IMEM_REQ  out  1  fetch request.
- IMEM_DATA  in  16  fetched instruction word.
- IMEM_READY  in  1  fetch data valid this cycle.
- PC_LE  in  1  PC update enable from control.
- PC_CONTROL  in  1  1: PC<=ALU_Y; 0: PC<=PC+1.
- ALU_Y  in  16  branch/jump target.
- NEXT_STAGE_LE  in  1  stage override enable.
- NEXT_STAGE  in  2  override target stage.
- HALTED  out  1  core halted.
- FETCH_ERR  out  1  fetch timed out (sticky).
- INSTR_COUNT  out  CNT_W  retired instruction count.

Behaviour:
- Reset: applied on a CLK edge with RST_N=0. Reset values: state=FETCH, STAGE=11, PC=RESET_PC, IR=16'h0000 (BR with no flags, i.e. a NOP), HALTED=0, FETCH_ERR=0, INSTR_COUNT=0, wait counter=0. Reset overrides every event in the same cycle, including mid-fetch; IMEM_REQ follows the state combinationally after that edge.
- States and encodings: FETCH (STAGE=11), DECODE (00), EXECUTE (01), WRITEBACK (10), HALT (STAGE=11).
- Transitions:
  - FETCH: IMEM_REQ = RUN. With IMEM_REQ=1 and IMEM_READY=1 at an edge: IR<=IMEM_DATA, go to DECODE, clear the wait counter. Otherwise remain in FETCH. One-cycle minimum fetch when READY is already high.
  - DECODE -> EXECUTE -> WRITEBACK is the default sequence.
  - WRITEBACK -> FETCH, or -> HALT if IR==16'hF025.
- Stage override:
  - NEXT_STAGE_LE=1 in DECODE, EXECUTE or WRITEBACK replaces the default next stage with NEXT_STAGE (11 means FETCH).
  - An override to 11 is treated as a WRITEBACK exit: the HALT check applies.
  - The override is ignored in FETCH and HALT.
- PC update: only when state=EXECUTE and PC_LE=1. PC<=PC_CONTROL ? ALU_Y : PC+1, with 16-bit wrap (FFFF+1 = 0000). PC_LE in any other state is ignored.
- Retire: INSTR_COUNT increments by 1 on every transition into FETCH or HALT from a non-fetch state, and wraps at 2^CNT_W.
- Timeout:
  - The wait counter increments on each edge with IMEM_REQ=1 and IMEM_READY=0. It holds while RUN=0.
  - When the counter equals FETCH_TIMEOUT-1 and READY is still 0: go to HALT, set FETCH_ERR=1.
  - If READY rises on that same cycle, the fetch completes normally (READY wins).
  - FETCH_TIMEOUT=0 disables the timeout.
- HALT: HALTED=1, IMEM_REQ=0. PC, IR and INSTR_COUNT are frozen. Exit only via reset.
- RUN=0: affects only the FETCH state. Stages in progress complete, then the block parks in FETCH with IMEM_REQ=0.
- IMEM_DATA is sampled only on the completing edge; it is a don't-care otherwise.

Test Plan:
1. Reset then RUN=1, READY always 1, IMEM_DATA=16'h1261 (ADD), PC_LE=1 in EXECUTE, PC_CONTROL=0 -> STAGE sequence 11,00,01,10,11. IMEM_ADDR=3000 then 3001. IR=1261. INSTR_COUNT=1 after 4 cycles.
2. READY held low 3 cycles, then high with data 16'h0E05 -> STAGE stays 11 for 4 cycles, IR=0E05 on the 4th edge, FETCH_ERR=0.
3. In EXECUTE drive PC_LE=1, PC_CONTROL=1, ALU_Y=16'h4000 -> PC=4000, next IMEM_ADDR=4000. Repeat with PC=FFFF and PC_CONTROL=0 -> PC=0000.
4. In EXECUTE drive NEXT_STAGE_LE=1, NEXT_STAGE=00 -> STAGE goes 01 to 00, no retire. Then NEXT_STAGE_LE=1, NEXT_STAGE=11 in DECODE -> FETCH, INSTR_COUNT+1.
5. Fetch 16'hF025 -> after WRITEBACK: HALTED=1, IMEM_REQ=0, STAGE=11, INSTR_COUNT frozen through 20 further cycles with READY toggling.
6. FETCH_TIMEOUT=4, READY=0 -> HALT and FETCH_ERR=1 after 4 wait edges. Rerun with READY=1 on the 4th cycle -> normal fetch, FETCH_ERR=0. RST_N=0 mid-fetch -> next cycle STAGE=11, PC=3000, all counters 0.
